spec_free_list: RTL

SPEC_FREE_LIST -- requirements
Module: spec_free_list

---
 rtl/spec_free_list.sv | 97 +++++++++
 1 files changed

// File: rtl/spec_free_list.sv
// Speculative physical-register free list: circular buffer of free pregs,
// compacted multi-lane allocate at rename, multi-lane release at commit.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   flush_i                - restore rd_ptr/cnt from arch_tail_i/arch_cnt_i
//   alloc_valid_i          - per-lane allocation request
//   alloc_ready_o          - every requested lane can be granted
//   alloc_preg_o           - granted preg per lane (compacted)
//   free_valid_i, free_preg_i - per-lane release
//   free_cnt_o             - registered free count
module spec_free_list #(
  parameter  int PHY_REG_NUM  = 64,
  parameter  int RENAME_WIDTH = 4,
  parameter  int COMMIT_WIDTH = 4,
  localparam int PW = $clog2(PHY_REG_NUM),
  localparam int CW = $clog2(PHY_REG_NUM + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [PW-1:0]                    arch_tail_i,
  input  logic [CW-1:0]                    arch_cnt_i,
  input  logic [RENAME_WIDTH-1:0]          alloc_valid_i,
  output logic                             alloc_ready_o,
  output logic [RENAME_WIDTH-1:0][PW-1:0]  alloc_preg_o,
  input  logic [COMMIT_WIDTH-1:0]          free_valid_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  free_preg_i,
  output logic [CW-1:0]                    free_cnt_o
);

  logic [PW-1:0] mem [PHY_REG_NUM];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic [CW-1:0] alloc_num;
  logic [CW-1:0] alloc_take;
  logic [CW-1:0] free_num;
  logic [PW-1:0] free_addr [COMMIT_WIDTH];
  logic [CW:0]   cnt_sum;
  logic          grant;

  // Lane i reads the entry offset by the number of valid lanes below it,
  // so holes in alloc_valid_i do not consume entries.
  always_comb begin
    alloc_num = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      alloc_preg_o[i] = mem[rd_ptr + alloc_num[PW-1:0]];
      alloc_num = alloc_num + CW'(alloc_valid_i[i]);
    end
  end

  always_comb begin
    free_num = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      free_addr[j] = wr_ptr + free_num[PW-1:0];
      free_num = free_num + CW'(free_valid_i[j]);
    end
  end

  assign alloc_ready_o = (cnt >= CW'(RENAME_WIDTH)) && !flush_i;
  assign grant         = alloc_ready_o && (|alloc_valid_i);
  assign alloc_take    = grant ? alloc_num : '0;
  // One extra bit so an overflowing free is observable.
  assign cnt_sum       = {1'b0, cnt} - {1'b0, alloc_take}
                       + {1'b0, free_num};
  assign free_cnt_o    = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= CW'(PHY_REG_NUM);
      for (int i = 0; i < PHY_REG_NUM; i++)
        mem[i] <= PW'(i);
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++)
        if (free_valid_i[j])
          mem[free_addr[j]] <= free_preg_i[j];
      wr_ptr <= wr_ptr + free_num[PW-1:0];
      if (flush_i) begin
        rd_ptr <= arch_tail_i;
        cnt    <= arch_cnt_i;
      end else begin
        if (grant)
          rd_ptr <= rd_ptr + alloc_num[PW-1:0];
        cnt <= cnt_sum[CW-1:0];
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !flush_i |-> (cnt_sum <= (CW+1)'(PHY_REG_NUM))
  );

endmodule
